// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard control: stall/flush generation, EX operand forwarding.
// Optional perf counters with `define HAZARD_PERF_CNT_EN.
//
// Ports:
//   cpu_clk, cpu_rst_n          clock, async active-low reset
//   rs1_ID, rs2_ID              ID-stage source registers
//   rs1_EX, rs2_EX, rd_EX       ID/EX register indices
//   load_EX, take_EX            EX is a load / EX redirects control flow
//   rd_MEM, rd_WB               writeback targets in MEM and WB
//   reg_write_MEM, reg_write_WB write enables for MEM and WB
//   dmem_req, dmem_ready        MEM-stage data access and its completion
//   stall_*, flush_*            pipeline register hold / bubble controls
//   fwd_a_sel, fwd_b_sel        00 regfile, 10 MEM, 01 WB
//   stall_cycles, flush_events  perf counters (HAZARD_PERF_CNT_EN only)
module pipeline_hazard_ctrl #(
    parameter int REGISTER_ADDR_WIDTH = 5,
    parameter int PERF_CNT_WIDTH      = 32
) (
    input  logic                           cpu_clk,
    input  logic                           cpu_rst_n,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rs1_ID,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rs2_ID,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rs1_EX,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rs2_EX,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rd_EX,
    input  logic                           load_EX,
    input  logic                           take_EX,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rd_MEM,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rd_WB,
    input  logic                           reg_write_MEM,
    input  logic                           reg_write_WB,
    input  logic                           dmem_req,
    input  logic                           dmem_ready,
    output logic                           stall_PC,
    output logic                           stall_IF_ID,
    output logic                           stall_ID_EX,
    output logic                           stall_EX_MEM,
    output logic                           flush_IF_ID,
    output logic                           flush_ID_EX,
    output logic                           flush_MEM_WB,
    output logic [1:0]                     fwd_a_sel,
`ifdef HAZARD_PERF_CNT_EN
    output logic [1:0]                     fwd_b_sel,
    output logic [PERF_CNT_WIDTH-1:0]      stall_cycles,
    output logic [PERF_CNT_WIDTH-1:0]      flush_events
`else
    output logic [1:0]                     fwd_b_sel
`endif
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t state;
    logic   mem_stall;
    logic   load_use;

    // Memory stall also covers the RUN cycle that launches the wait,
    // and drops on the cycle the access completes.
    assign mem_stall = !dmem_ready && ((state == MEM_WAIT) || dmem_req);

    assign load_use = load_EX && (rd_EX != '0) &&
                      ((rd_EX == rs1_ID) || (rd_EX == rs2_ID));

    always_comb begin
        stall_PC     = 1'b0;
        stall_IF_ID  = 1'b0;
        stall_ID_EX  = 1'b0;
        stall_EX_MEM = 1'b0;
        flush_IF_ID  = 1'b0;
        flush_ID_EX  = 1'b0;
        flush_MEM_WB = 1'b0;
        // Reset gates outputs so an async reset clears them at once.
        if (cpu_rst_n) begin
            if (mem_stall) begin
                stall_PC     = 1'b1;
                stall_IF_ID  = 1'b1;
                stall_ID_EX  = 1'b1;
                stall_EX_MEM = 1'b1;
                flush_MEM_WB = 1'b1;
            end else if (take_EX) begin
                flush_IF_ID = 1'b1;
                flush_ID_EX = 1'b1;
            end else if (load_use) begin
                stall_PC    = 1'b1;
                stall_IF_ID = 1'b1;
                flush_ID_EX = 1'b1;
            end
        end
    end

    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (cpu_rst_n) begin
            if (reg_write_MEM && rd_MEM != '0 && rd_MEM == rs1_EX)
                fwd_a_sel = 2'b10;
            else if (reg_write_WB && rd_WB != '0 && rd_WB == rs1_EX)
                fwd_a_sel = 2'b01;
            if (reg_write_MEM && rd_MEM != '0 && rd_MEM == rs2_EX)
                fwd_b_sel = 2'b10;
            else if (reg_write_WB && rd_WB != '0 && rd_WB == rs2_EX)
                fwd_b_sel = 2'b01;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state <= RUN;
        end else begin
            unique case (state)
                RUN:      if (dmem_req && !dmem_ready) state <= MEM_WAIT;
                MEM_WAIT: if (dmem_ready) state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_PC)
                stall_cycles <= stall_cycles + PERF_CNT_WIDTH'(1);
            if (flush_IF_ID)
                flush_events <= flush_events + PERF_CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl.
// Inputs change 1ns after posedge; outputs are checked at negedge.
module tb_pipeline_hazard_ctrl;

    logic       cpu_clk = 1'b0;
    logic       cpu_rst_n;
    logic [4:0] rs1_ID, rs2_ID, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB;
    logic       load_EX, take_EX, reg_write_MEM, reg_write_WB;
    logic       dmem_req, dmem_ready;
    logic       stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM;
    logic       flush_IF_ID, flush_ID_EX, flush_MEM_WB;
    logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events;
    logic [31:0] base_s, base_f;
`endif

    int checks = 0;
    int errors = 0;

    // {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
    //  flush_IF_ID, flush_ID_EX, flush_MEM_WB}
    logic [6:0] ctl;
    assign ctl = {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
                  flush_IF_ID, flush_ID_EX, flush_MEM_WB};

    localparam logic [6:0] NONE = 7'b0000_000;
    localparam logic [6:0] LU   = 7'b1100_010;
    localparam logic [6:0] TAKE = 7'b0000_110;
    localparam logic [6:0] MEMS = 7'b1111_001;

    always #5 cpu_clk = ~cpu_clk;

    pipeline_hazard_ctrl dut (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_EX(rd_EX),
        .load_EX(load_EX), .take_EX(take_EX),
        .rd_MEM(rd_MEM), .rd_WB(rd_WB),
        .reg_write_MEM(reg_write_MEM), .reg_write_WB(reg_write_WB),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .stall_PC(stall_PC), .stall_IF_ID(stall_IF_ID),
        .stall_ID_EX(stall_ID_EX), .stall_EX_MEM(stall_EX_MEM),
        .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
        .flush_MEM_WB(flush_MEM_WB),
        .fwd_a_sel(fwd_a_sel),
`ifdef HAZARD_PERF_CNT_EN
        .fwd_b_sel(fwd_b_sel),
        .stall_cycles(stall_cycles),
        .flush_events(flush_events)
`else
        .fwd_b_sel(fwd_b_sel)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        rs1_ID = 0; rs2_ID = 0; rs1_EX = 0; rs2_EX = 0; rd_EX = 0;
        rd_MEM = 0; rd_WB = 0; load_EX = 0; take_EX = 0;
        reg_write_MEM = 0; reg_write_WB = 0;
        dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic next();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic hazard5();
        load_EX = 1; rd_EX = 5; rs1_ID = 5; rs2_ID = 2;
    endtask

    initial begin
        clr();
        cpu_rst_n = 1'b0;
        // Reset with every hazard and forward condition active.
        hazard5(); take_EX = 1; dmem_req = 1;
        rd_MEM = 7; rd_WB = 7; reg_write_MEM = 1; reg_write_WB = 1;
        rs1_EX = 7; rs2_EX = 7;
        @(negedge cpu_clk);
        chk("rst_ctl", 32'(ctl), 32'(NONE));
        chk("rst_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'h0);
`ifdef HAZARD_PERF_CNT_EN
        chk("rst_cnt", stall_cycles | flush_events, 0);
`endif
        clr();
        #2 cpu_rst_n = 1'b1;
        next();
        @(negedge cpu_clk);
        chk("idle", 32'(ctl), 32'(NONE));

        // Load-use on rs1: one stall cycle, then bubble clears it.
        next(); hazard5();
        @(negedge cpu_clk);
        chk("lu_rs1", 32'(ctl), 32'(LU));
        next(); load_EX = 0; rd_EX = 0;
        @(negedge cpu_clk);
        chk("lu_done", 32'(ctl), 32'(NONE));

        next(); load_EX = 1; rd_EX = 9; rs1_ID = 3; rs2_ID = 9;
        @(negedge cpu_clk);
        chk("lu_rs2", 32'(ctl), 32'(LU));
        next(); load_EX = 1; rd_EX = 0; rs1_ID = 0; rs2_ID = 0;
        @(negedge cpu_clk);
        chk("lu_x0", 32'(ctl), 32'(NONE));
        next(); load_EX = 0; rd_EX = 5; rs1_ID = 5;
        @(negedge cpu_clk);
        chk("no_load", 32'(ctl), 32'(NONE));
        next(); load_EX = 1; rd_EX = 5; rs1_ID = 4; rs2_ID = 6;
        @(negedge cpu_clk);
        chk("lu_nomatch", 32'(ctl), 32'(NONE));

        // Taken branch beats load-use.
        next(); clr(); hazard5(); take_EX = 1;
`ifdef HAZARD_PERF_CNT_EN
        base_f = flush_events;
`endif
        @(negedge cpu_clk);
        chk("take_lu", 32'(ctl), 32'(TAKE));
        next(); clr();
        @(negedge cpu_clk);
        chk("take_done", 32'(ctl), 32'(NONE));
`ifdef HAZARD_PERF_CNT_EN
        chk("flush_cnt", flush_events - base_f, 1);
`endif

        // Memory wait: ready low for 3 cycles.
`ifdef HAZARD_PERF_CNT_EN
        base_s = stall_cycles;
`endif
        next(); dmem_req = 1; dmem_ready = 0;
        @(negedge cpu_clk);
        chk("mem_c1", 32'(ctl), 32'(MEMS));
        next(); take_EX = 1; hazard5();
        rd_MEM = 7; reg_write_MEM = 1; rs1_EX = 7;
        @(negedge cpu_clk);
        chk("mem_c2_prio", 32'(ctl), 32'(MEMS));
        chk("mem_fwd", 32'(fwd_a_sel), 32'h2);
        next(); clr(); dmem_req = 0;
        @(negedge cpu_clk);
        chk("mem_c3_noreq", 32'(ctl), 32'(MEMS));
        next(); dmem_req = 1; dmem_ready = 1;
        @(negedge cpu_clk);
        chk("mem_ready", 32'(ctl), 32'(NONE));
        next(); dmem_req = 0; dmem_ready = 0;
        @(negedge cpu_clk);
        chk("mem_run", 32'(ctl), 32'(NONE));
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cnt", stall_cycles - base_s, 3);
`endif

        // Forwarding.
        next(); rd_MEM = 7; rd_WB = 7; reg_write_MEM = 1;
        reg_write_WB = 1; rs1_EX = 7; rs2_EX = 0;
        @(negedge cpu_clk);
        chk("fwd_a_mem", 32'(fwd_a_sel), 32'h2);
        chk("fwd_b_x0", 32'(fwd_b_sel), 32'h0);
        next(); rd_MEM = 0; rs2_EX = 7;
        @(negedge cpu_clk);
        chk("fwd_a_wb", 32'(fwd_a_sel), 32'h1);
        chk("fwd_b_wb", 32'(fwd_b_sel), 32'h1);
        next(); rd_MEM = 7; reg_write_MEM = 0; reg_write_WB = 0;
        @(negedge cpu_clk);
        chk("fwd_no_we", 32'({fwd_a_sel, fwd_b_sel}), 32'h0);
        next(); reg_write_MEM = 1; rs1_EX = 3; rs2_EX = 7;
        @(negedge cpu_clk);
        chk("fwd_b_mem", 32'({fwd_a_sel, fwd_b_sel}), 32'h2);

        // Async reset during MEM_WAIT.
        next(); clr(); dmem_req = 1;
        next(); dmem_req = 0;
        rd_MEM = 7; reg_write_MEM = 1; rs1_EX = 7; rs2_EX = 7;
        @(negedge cpu_clk);
        chk("wait_pre", 32'(ctl), 32'(MEMS));
        #2 cpu_rst_n = 1'b0;
        #1;
        chk("arst_ctl", 32'(ctl), 32'(NONE));
        chk("arst_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'h0);
`ifdef HAZARD_PERF_CNT_EN
        chk("arst_cnt", stall_cycles | flush_events, 0);
`endif
        next();
        #2 cpu_rst_n = 1'b1;
        @(negedge cpu_clk);
        chk("post_rst_run", 32'(ctl), 32'(NONE));
        chk("post_rst_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'ha);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
